// File: rtl/core_pkg.sv
// Shared fetch-frontend types and constants.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if;
    import core_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush dominates push and pop.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fq_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fq_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues imem requests under a credit rule, buffers
// responses and handles redirects. Optional counters enabled by FETCH_PERF_EN.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     FQ_DEPTH  = 2,
    parameter int unsigned     MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_stage_if.master     imem,
    output logic [XLEN-1:0]   instr2,
    output logic [XLEN-1:0]   pc2,
    output logic              valid2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int unsigned OC_W  = $clog2(MAX_OUTST + 1);
    localparam int unsigned FC_W  = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(FQ_DEPTH + MAX_OUTST + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] pc_hold_q;
    logic [OC_W-1:0] out_cnt_q, out_cnt_d;
    logic [OC_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [OC_W-1:0] in_flight;
    logic [XLEN-1:0] redirect_tgt;
    logic            req;
    logic            fire;
    logic            push;
    logic            pop;
    logic            flush;
    logic [FC_W-1:0] fq_count;
    logic            fq_empty;
    logic            fq_full;
    fq_entry_t       fq_head;
    fq_entry_t       push_data;

    // Responses still owed after this cycle's rvalid is consumed.
    assign in_flight    = out_cnt_q - OC_W'(imem.imem_rvalid);
    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign push_data    = '{instr: imem.imem_rdata, pc: resp_pc_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        req        = 1'b0;
        fire       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        if (state_q == BOOT) begin
            state_d = RUN;
            if (redirect) begin
                fetch_pc_d = redirect_tgt;
                resp_pc_d  = redirect_tgt;
            end
        end else if (redirect) begin
            // Wrong-path words still in flight are counted off as they return.
            flush      = 1'b1;
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            out_cnt_d  = in_flight;
            drop_cnt_d = in_flight;
            state_d    = (in_flight != '0) ? DRAIN : RUN;
        end else begin
            req  = ~rst && (out_cnt_q < OC_W'(MAX_OUTST))
                        && ((SUM_W'(out_cnt_q) + SUM_W'(fq_count)) < SUM_W'(FQ_DEPTH));
            fire = req & imem.imem_ready;
            pop  = ~fq_empty & ~stall;
            if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            out_cnt_d = out_cnt_q + OC_W'(fire) - OC_W'(imem.imem_rvalid);
            if (imem.imem_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - OC_W'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
            if (state_q == DRAIN && drop_cnt_d == '0) state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            pc_hold_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pc_hold_q  <= pc2;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (fq_head),
        .count     (fq_count),
        .empty     (fq_empty),
        .full      (fq_full)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;
    assign valid2         = ~fq_empty;
    assign instr2         = fq_empty ? NOP_INSTR : fq_head.instr;
    assign pc2            = fq_empty ? pc_hold_q : fq_head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (push)             perf_fetched <= perf_fetched + 32'd1;
            if (!valid2 && !stall) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fq_full && !pop));
    a_outst_max:   assert property (@(posedge clk) disable iff (rst) out_cnt_q <= OC_W'(MAX_OUTST));
    a_drop_le_out: assert property (@(posedge clk) disable iff (rst) drop_cnt_q <= out_cnt_q);

endmodule
